// File: rtl/hbridge_pkg.sv
// Shared encodings for the two-channel H-bridge output stage.
package hbridge_pkg;

  // Duty and PWM counter width
  localparam int DATA_W = 8;

  // Command direction encodings
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  // Per-channel bridge state
  typedef enum logic [2:0] {
    CH_IDLE,
    CH_RUN,
    CH_BRAKE,
    CH_DEAD,
    CH_FAULT
  } ch_state_e;

endpackage

// File: rtl/hbridge_channel.sv
// One bridge side: state machine, dead-time counter, duty ramp and
// registered IN/PWM drive. Outputs are forced low the same cycle the
// synchronized fault is seen so the bridge is released within 3 clk.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int DEAD_CYCLES = 5000,
  parameter int RAMP_STEP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fault_s,
  input  logic              clear_fault,
  input  logic              period_end,
  input  logic [DATA_W-1:0] pwm_cnt,
  input  logic [1:0]        target_dir,
  input  logic [DATA_W-1:0] target_duty,
  output logic              in_a,
  output logic              in_b,
  output logic              pwm_out,
  output logic              in_dead,
  output logic              in_fault
);

  localparam int DCNT_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DEAD_LOAD = DCNT_W'(DEAD_CYCLES - 1);
  localparam logic signed [DATA_W+1:0] STEP_S = (DATA_W + 2)'(RAMP_STEP);

  ch_state_e         state_q, state_d;
  logic [1:0]        dir_q, dir_d;
  logic [DATA_W-1:0] duty_cur_q, duty_cur_d;
  logic [DCNT_W-1:0] dead_cnt_q, dead_cnt_d;
  logic              in_a_q, in_a_d;
  logic              in_b_q, in_b_d;
  logic              pwm_q, pwm_d;

  // Move one ramp step toward the target, landing exactly on it when
  // closer than a step; the widened signed difference cannot wrap.
  function automatic logic [DATA_W-1:0] ramp_sat(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] tgt);
    logic signed [DATA_W+1:0] cur_s;
    logic signed [DATA_W+1:0] tgt_s;
    logic signed [DATA_W+1:0] diff_s;
    logic signed [DATA_W+1:0] next_s;
    cur_s  = signed'({2'b00, cur});
    tgt_s  = signed'({2'b00, tgt});
    diff_s = tgt_s - cur_s;
    if (diff_s > STEP_S) begin
      next_s = cur_s + STEP_S;
    end else if (diff_s < -STEP_S) begin
      next_s = cur_s - STEP_S;
    end else begin
      next_s = tgt_s;
    end
    return DATA_W'(next_s);
  endfunction

  // Next state, applied direction, ramped duty and dead-time count
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    duty_cur_d = duty_cur_q;
    dead_cnt_d = dead_cnt_q;
    if (fault_s) begin
      state_d    = CH_FAULT;
      duty_cur_d = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          duty_cur_d = '0;
          if (target_dir == DIR_FWD || target_dir == DIR_REV) begin
            state_d = CH_RUN;
            dir_d   = target_dir;
          end else if (target_dir == DIR_BRAKE) begin
            state_d = CH_BRAKE;
          end
        end
        CH_RUN: begin
          if (target_dir != dir_q) begin
            state_d    = CH_DEAD;
            dead_cnt_d = DEAD_LOAD;
            duty_cur_d = '0;
          end else if (period_end) begin
            duty_cur_d = ramp_sat(duty_cur_q, target_duty);
          end
        end
        CH_BRAKE: begin
          duty_cur_d = '0;
          if (target_dir != DIR_BRAKE) begin
            state_d    = CH_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end
        end
        CH_DEAD: begin
          duty_cur_d = '0;
          if (dead_cnt_q == '0) begin
            state_d = CH_IDLE;
          end else begin
            dead_cnt_d = dead_cnt_q - 1'b1;
          end
        end
        CH_FAULT: begin
          duty_cur_d = '0;
          if (clear_fault) begin
            state_d = CH_IDLE;
          end
        end
        default: begin
          state_d    = CH_IDLE;
          duty_cur_d = '0;
        end
      endcase
    end
  end

  // Bridge pin levels for the current state, all low under a fault
  always_comb begin
    in_a_d = 1'b0;
    in_b_d = 1'b0;
    pwm_d  = 1'b0;
    if (!fault_s) begin
      case (state_q)
        CH_RUN: begin
          in_a_d = (dir_q == DIR_FWD);
          in_b_d = (dir_q == DIR_REV);
          pwm_d  = (pwm_cnt < duty_cur_q);
        end
        CH_BRAKE: begin
          in_a_d = 1'b1;
          in_b_d = 1'b1;
          pwm_d  = 1'b1;
        end
        default: begin
          in_a_d = 1'b0;
        end
      endcase
    end
  end

  // State machine and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CH_IDLE;
      dir_q      <= DIR_COAST;
      duty_cur_q <= '0;
      dead_cnt_q <= '0;
      in_a_q     <= 1'b0;
      in_b_q     <= 1'b0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      duty_cur_q <= duty_cur_d;
      dead_cnt_q <= dead_cnt_d;
      in_a_q     <= in_a_d;
      in_b_q     <= in_b_d;
      pwm_q      <= pwm_d;
    end
  end

  assign in_a     = in_a_q;
  assign in_b     = in_b_q;
  assign pwm_out  = pwm_q;
  assign in_dead  = (state_q == CH_DEAD);
  assign in_fault = (state_q == CH_FAULT);

endmodule

// File: rtl/hbridge_drive.sv
// Two-channel H-bridge output stage: shared PWM timebase, command
// targets, fault synchronizers and the two channel controllers.
module hbridge_drive
  import hbridge_pkg::*;
#(
  parameter int PRESCALE    = 196,
  parameter int DEAD_CYCLES = 5000,
  parameter int RAMP_STEP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_dir_l,
  input  logic [1:0]        cmd_dir_r,
  input  logic [DATA_W-1:0] cmd_duty_l,
  input  logic [DATA_W-1:0] cmd_duty_r,
  input  logic              fault_l,
  input  logic              fault_r,
  input  logic              clear_fault,
  output logic              IN1,
  output logic              IN2,
  output logic              IN3,
  output logic              IN4,
  output logic              PWM_out_L,
  output logic              PWM_out_R,
  output logic [1:0]        fault_latched
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]   presc_q, presc_d;
  logic [DATA_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [1:0]        tdir_l_q, tdir_l_d, tdir_r_q, tdir_r_d;
  logic [DATA_W-1:0] tduty_l_q, tduty_l_d, tduty_r_q, tduty_r_d;
  logic              fault_l_p0, fault_l_p1, fault_r_p0, fault_r_p1;
  logic              tick, period_end;
  logic              dead_l, dead_r, flt_l, flt_r;

  assign tick       = (presc_q == PS_LAST);
  assign period_end = tick && (pwm_cnt_q == '1);
  assign cmd_ready  = ~(dead_l | dead_r);

  // Prescaler and 8-bit PWM counter
  always_comb begin
    presc_d   = presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q;
    if (tick) begin
      presc_d   = '0;
      pwm_cnt_d = pwm_cnt_q + 1'b1;
    end
  end

  // Both channel targets load together on an accepted command
  always_comb begin
    tdir_l_d  = tdir_l_q;
    tdir_r_d  = tdir_r_q;
    tduty_l_d = tduty_l_q;
    tduty_r_d = tduty_r_q;
    if (cmd_valid && cmd_ready) begin
      tdir_l_d  = cmd_dir_l;
      tdir_r_d  = cmd_dir_r;
      tduty_l_d = cmd_duty_l;
      tduty_r_d = cmd_duty_r;
    end
  end

  // Timebase, targets and 2-FF fault synchronizers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_cnt_q  <= '0;
      tdir_l_q   <= DIR_COAST;
      tdir_r_q   <= DIR_COAST;
      tduty_l_q  <= '0;
      tduty_r_q  <= '0;
      fault_l_p0 <= 1'b0;
      fault_l_p1 <= 1'b0;
      fault_r_p0 <= 1'b0;
      fault_r_p1 <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_cnt_q  <= pwm_cnt_d;
      tdir_l_q   <= tdir_l_d;
      tdir_r_q   <= tdir_r_d;
      tduty_l_q  <= tduty_l_d;
      tduty_r_q  <= tduty_r_d;
      fault_l_p0 <= fault_l;
      fault_l_p1 <= fault_l_p0;
      fault_r_p0 <= fault_r;
      fault_r_p1 <= fault_r_p0;
    end
  end

  hbridge_channel #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_STEP  (RAMP_STEP)
  ) u_ch_l (
    .clk        (clk),
    .rst        (rst),
    .fault_s    (fault_l_p1),
    .clear_fault(clear_fault),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt_q),
    .target_dir (tdir_l_q),
    .target_duty(tduty_l_q),
    .in_a       (IN1),
    .in_b       (IN2),
    .pwm_out    (PWM_out_L),
    .in_dead    (dead_l),
    .in_fault   (flt_l)
  );

  hbridge_channel #(
    .DEAD_CYCLES(DEAD_CYCLES),
    .RAMP_STEP  (RAMP_STEP)
  ) u_ch_r (
    .clk        (clk),
    .rst        (rst),
    .fault_s    (fault_r_p1),
    .clear_fault(clear_fault),
    .period_end (period_end),
    .pwm_cnt    (pwm_cnt_q),
    .target_dir (tdir_r_q),
    .target_duty(tduty_r_q),
    .in_a       (IN3),
    .in_b       (IN4),
    .pwm_out    (PWM_out_R),
    .in_dead    (dead_r),
    .in_fault   (flt_r)
  );

  assign fault_latched = {flt_r, flt_l};

endmodule
